// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmitter, frames one parallel word per handshake onto a registered serial line.
// Frame: start(0), DATA_W data bits LSB first, optional parity, stop(1), optional 2nd stop.
// Each bit cell lasts max(prescale,1) clk cycles.
// Ports:
//   clk        TX clock (baud x prescale)
//   rst        asynchronous, active-low reset
//   p_data     parallel word, captured on acceptance
//   data_valid request, accepted only while idle
//   par_en     1 = insert parity bit
//   par_typ    0 = even parity, 1 = odd parity
//   prescale   clk cycles per bit, 0 treated as 1
//   stop2      2nd stop bit request (only with UART_TX_TWO_STOP_EN defined)
//   tx_out     serial line, idle high, registered
//   busy       high while a frame is on the line, registered
// Define UART_TX_TWO_STOP_EN to build the stop2 port and the STOP2 state.
module uart_tx_serializer #(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [PRESCALE_W-1:0] prescale,
`ifdef UART_TX_TWO_STOP_EN
  input  logic                  stop2,
`endif
  output logic                  tx_out,
  output logic                  busy
);
  localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  typedef enum logic [2:0] {
`ifdef UART_TX_TWO_STOP_EN
    STOP2,
`endif
    IDLE, START, DATA, PARITY, STOP
  } state_t;
  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d, pre_q, pre_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic                  par_q, par_d, par_en_q, par_en_d, tx_q, tx_d, busy_q, busy_d;
  logic                  last;
`ifdef UART_TX_TWO_STOP_EN
  logic                  stop2_q, stop2_d;
`endif
  // pre_q already holds max(prescale,1), so the cell ends at pre_q-1
  assign last   = cnt_q == pre_q - 1'b1;
  assign tx_out = tx_q;
  assign busy   = busy_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pre_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pre_q    <= pre_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      par_en_q <= par_en_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q  <= stop2_d;
`endif
    end
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = (state_q == IDLE || last) ? '0 : cnt_q + 1'b1;
    pre_d    = pre_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    par_en_d = par_en_q;
`ifdef UART_TX_TWO_STOP_EN
    stop2_d  = stop2_q;
`endif
    case (state_q)
      IDLE: if (data_valid) begin
        state_d  = START;
        shift_d  = p_data;
        par_d    = par_typ ? ~^p_data : ^p_data;
        par_en_d = par_en;
        pre_d    = (prescale == '0) ? PRESCALE_W'(1) : prescale;
        bit_d    = '0;
`ifdef UART_TX_TWO_STOP_EN
        stop2_d  = stop2;
`endif
      end
      START:  if (last) state_d = DATA;
      DATA: if (last) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 1'b1;
        if (bit_q == BW'(DATA_W - 1)) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: if (last) state_d = STOP;
`ifdef UART_TX_TWO_STOP_EN
      STOP:   if (last) state_d = stop2_q ? STOP2 : IDLE;
      STOP2:  if (last) state_d = IDLE;
`else
      STOP:   if (last) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
    // line level is registered from the state being entered, so it lines up with the cell
    tx_d   = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_d : 1'b1;
    busy_d = state_d != IDLE;
  end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: scoreboard bench for uart_tx_serializer, frames checked cell by cell.
module tb_uart_tx_serializer;
  typedef struct {
    logic [11:0] bits;
    int          n;
    int          p;
    int          gap;
    bit          abort;
  } exp_t;
  logic       clk = 1'b0, rst = 1'b0, data_valid = 1'b0, par_en = 1'b0, par_typ = 1'b0, stop2 = 1'b0;
  logic [7:0] p_data = '0;
  logic [5:0] prescale = '0;
  logic       tx_out, busy;
  int         checks = 0, errors = 0;
  exp_t       q[$];
  exp_t       cur;
  bit         active = 0, prev_busy = 0, idle_bad = 0;
  int         cyc = 0, idle = 0;
  logic       cell_val;
  always #5 clk = ~clk;
  uart_tx_serializer dut (
    .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
    .par_en(par_en), .par_typ(par_typ), .prescale(prescale),
`ifdef UART_TX_TWO_STOP_EN
    .stop2(stop2),
`endif
    .tx_out(tx_out), .busy(busy)
  );
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (active && !cur.abort) chk("frame_cut_by_reset", 1, 0);
        active = 0; prev_busy = 0; idle = 0; idle_bad = 0;
      end else begin
        if (busy && !prev_busy) begin
          chk("idle_line_high", idle_bad, 0);
          idle_bad = 0;
          if (q.size() == 0) chk("unexpected_frame", 1, 0);
          else begin
            cur = q.pop_front();
            active = 1;
            cyc = 0;
            if (cur.gap >= 0) chk("inter_frame_gap", idle, cur.gap);
          end
        end
        if (active && busy) begin
          if (cyc < cur.n * cur.p) begin
            if (cyc % cur.p == 0) cell_val = cur.bits[cyc / cur.p];
            if (tx_out !== cur.bits[cyc / cur.p]) cell_val = tx_out;
            if (cyc % cur.p == cur.p - 1) chk($sformatf("bit%0d_cell", cyc / cur.p), cell_val, cur.bits[cyc / cur.p]);
          end
          cyc++;
        end else if (active) begin
          chk("busy_length", cyc, cur.n * cur.p);
          active = 0;
        end
        if (!busy && tx_out !== 1'b1) idle_bad = 1;
        idle = busy ? 0 : idle + 1;
        prev_busy = busy;
      end
    end
  end
  task automatic wait_busy(logic lvl, string name);
    int t = 0;
    while (busy !== lvl && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    if (busy !== lvl) chk(name, busy, lvl);
  endtask
  task automatic send(logic [7:0] d, logic pe, logic pt, logic [5:0] ps, logic s2,
                      logic [11:0] bits, int n, int p);
    wait_busy(1'b0, "wait_idle_timeout");
    @(posedge clk); #1;
    p_data = d; par_en = pe; par_typ = pt; prescale = ps; stop2 = s2; data_valid = 1'b1;
    q.push_back('{bits, n, p, -1, 1'b0});
    @(posedge clk); #1;
    data_valid = 1'b0;
  endtask
  initial begin : stimulus
    int t;
    data_valid = 1'b1; p_data = 8'hC3; par_en = 1'b1; par_typ = 1'b1; prescale = 6'd3;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("reset_tx_high", tx_out, 1);
      chk("reset_busy_low", busy, 0);
    end
    q.push_back('{12'h786, 11, 3, -1, 1'b0});
    rst = 1'b1;
    @(posedge clk); #1;
    chk("accept_latency_busy", busy, 1);
    chk("accept_latency_tx", tx_out, 0);
    data_valid = 1'b0;
    send(8'hA5, 1'b1, 1'b0, 6'd8, 1'b0, 12'h54A, 11, 8);
    send(8'h01, 1'b1, 1'b1, 6'd8, 1'b0, 12'h402, 11, 8);
    send(8'h01, 1'b0, 1'b0, 6'd8, 1'b0, 12'h202, 10, 8);
    wait_busy(1'b0, "wait_idle_timeout");
    @(posedge clk); #1;
    p_data = 8'h3C; par_en = 1'b0; par_typ = 1'b0; prescale = 6'd4; data_valid = 1'b1;
    q.push_back('{12'h278, 10, 4, -1, 1'b0});
    q.push_back('{12'h5FE, 11, 2, 1, 1'b0});
    repeat (12) @(posedge clk);
    #1;
    p_data = 8'hFF; par_en = 1'b1; prescale = 6'd2;
    wait_busy(1'b0, "first_frame_end_timeout");
    wait_busy(1'b1, "second_frame_start_timeout");
    data_valid = 1'b0;
    send(8'h00, 1'b0, 1'b0, 6'd4, 1'b0, 12'h200, 10, 4);
    q[q.size() - 1].abort = 1'b1;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("midframe_reset_tx", tx_out, 1);
    chk("midframe_reset_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_reset_idle_tx", tx_out, 1);
      chk("post_reset_idle_busy", busy, 0);
    end
    send(8'h81, 1'b0, 1'b0, 6'd0, 1'b0, 12'h302, 10, 1);
    send(8'h5A, 1'b1, 1'b0, 6'd32, 1'b0, 12'h4B4, 11, 32);
`ifdef UART_TX_TWO_STOP_EN
    send(8'h96, 1'b0, 1'b0, 6'd16, 1'b1, 12'h72C, 11, 16);
`endif
    t = 0;
    while ((active || q.size() != 0) && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("scoreboard_drained", q.size(), 0);
    chk("monitor_idle", active, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
